// File: rtl/cdc_arb_pkg.sv
// cdc_arb_pkg: state encoding and counter sizing shared by the CDC transmit arbiter.
package cdc_arb_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    function automatic int cnt_width(input int guard);
        return $clog2(guard + 1);
    endfunction
endpackage

// File: rtl/arb_rr_picker.sv
// arb_rr_picker: round-robin winner select; lowest-index priority when CDC_ARB_FIXED_PRIO_EN is defined.
module arb_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
`ifndef CDC_ARB_FIXED_PRIO_EN
    input  logic [IW-1:0] ptr,
`endif
    input  logic [N-1:0]  req,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx
);
    always_comb begin
        int j;
        logic found;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
`ifdef CDC_ARB_FIXED_PRIO_EN
            j = k - 1;
`else
            j = (int'(ptr) + k) % N;
`endif
            if (!found && |(req & (N'(1) << j))) begin
                found = 1'b1;
                win   = N'(1) << j;
                idx   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: shares one CDC handshake transmitter among NUM_REQ requesters with a guard window.
// Define CDC_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cdc_tx_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WID_DATA     = 8,
    parameter int GUARD_CYCLES = 12
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [NUM_REQ*WID_DATA-1:0]  ReqData,
    output logic [NUM_REQ-1:0]           Grant,
    output logic [WID_DATA-1:0]          T_Data,
    output logic                         T_Start,
    output logic                         Busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(GUARD_CYCLES);
    logic [1:0]          state, state_nxt;
    logic [IW-1:0]       sel, win_idx;
    logic [NUM_REQ-1:0]  win;
    logic [CW-1:0]       cnt;
    logic [WID_DATA-1:0] cap;
    wire                 take = (state == ST_IDLE) && |Req;
`ifndef CDC_ARB_FIXED_PRIO_EN
    logic [IW-1:0]       ptr;
`endif
    arb_rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
`ifndef CDC_ARB_FIXED_PRIO_EN
        .ptr (ptr),
`endif
        .req (Req),
        .win (win),
        .idx (win_idx)
    );
    always_comb begin
        cap = '0;
        for (int i = 0; i < NUM_REQ; i++)
            cap = cap | (win[i] ? ReqData[i*WID_DATA +: WID_DATA] : '0);
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= ST_IDLE;
            sel    <= '0;
            cnt    <= '0;
            T_Data <= '0;
`ifndef CDC_ARB_FIXED_PRIO_EN
            ptr    <= IW'(NUM_REQ - 1);
`endif
        end else begin
            state <= state_nxt;
            if (take) begin
                T_Data <= cap;
                sel    <= win_idx;
            end
            if (state == ST_ISSUE) begin
                cnt <= CW'(GUARD_CYCLES - 1);
`ifndef CDC_ARB_FIXED_PRIO_EN
                ptr <= sel;
`endif
            end else if (state == ST_GUARD && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
    // Req is deliberately ignored outside IDLE so the channel round trip completes
    always_comb begin
        state_nxt = state == ST_IDLE  ? (|Req ? ST_ISSUE : ST_IDLE) :
                    state == ST_ISSUE ? ST_GUARD :
                    state == ST_GUARD ? (cnt == '0 ? ST_IDLE : ST_GUARD) : ST_IDLE;
    end
    always_comb begin
        T_Start = state == ST_ISSUE;
        Grant   = T_Start ? (NUM_REQ'(1) << sel) : '0;
        Busy    = state == ST_ISSUE || state == ST_GUARD;
    end
endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb_cdc_tx_arbiter: directed checks of issue latency, guard spacing, arbitration order and reset.
module tb_cdc_tx_arbiter;
`ifdef CDC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  Req;
    logic [31:0] ReqData;
    logic [3:0]  Grant;
    logic [7:0]  T_Data;
    logic        T_Start;
    logic        Busy;
    int          vectors = 0;
    int          errs = 0;
    logic [7:0]  data_tbl [4] = '{8'h11, 8'h22, 8'hA5, 8'h33};

    cdc_tx_arbiter #(.NUM_REQ(4), .WID_DATA(8), .GUARD_CYCLES(12)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req),
        .ReqData (ReqData),
        .Grant   (Grant),
        .T_Data  (T_Data),
        .T_Start (T_Start),
        .Busy    (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_start(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!T_Start && cycles < 60);
        if (!T_Start) chk("start_timeout", 32'(T_Start), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 60) begin
            tick();
            n++;
        end
        if (Busy) chk("idle_timeout", 32'(Busy), 32'd0);
    endtask

    initial begin
        int cyc, busy_cnt, starts;
        Reset   = 1'b0;
        Req     = '0;
        ReqData = {data_tbl[3], data_tbl[2], data_tbl[1], data_tbl[0]};
        #8;
        chk("rst_tstart", 32'(T_Start), 32'd0);
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_tdata", 32'(T_Data), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        #14 Reset = 1'b1;
        tick();
        // single request
        Req = 4'b0100;
        wait_start(cyc);
        chk("single_lat", 32'(cyc), 32'd1);
        chk("single_grant", 32'(Grant), 32'h4);
        chk("single_tdata", 32'(T_Data), 32'hA5);
        Req = '0;
        busy_cnt = 1;
        for (int i = 0; i < 30 && Busy; i++) begin
            tick();
            if (Busy) busy_cnt++;
            if (i == 0) chk("single_pulse", 32'(T_Start), 32'd0);
        end
        chk("single_busy_len", 32'(busy_cnt), 32'd13);
        chk("single_tdata_hold", 32'(T_Data), 32'hA5);
        // all requesting from fresh reset
        #1 Reset = 1'b0;
        tick();
        Reset = 1'b1;
        Req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int e;
            e = FIXED ? 0 : i % 4;
            wait_start(cyc);
            chk("all_spacing", 32'(cyc), i == 0 ? 32'd1 : 32'd14);
            chk("all_grant", 32'(Grant), 32'(4'b1 << e));
            chk("all_tdata", 32'(T_Data), 32'(data_tbl[e]));
        end
        // request arriving during guard cycle 5
        Req = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("guard_busy", 32'(Busy), 32'd1);
        Req = 4'b1000;
        wait_start(cyc);
        chk("guard_wait", 32'(cyc), 32'd9);
        chk("guard_grant", 32'(Grant), 32'h8);
        chk("guard_tdata", 32'(T_Data), 32'h33);
        Req = '0;
        wait_idle();
        // withdrawn request
        Req = 4'b0010;
        wait_start(cyc);
        Req = '0;
        chk("wd_grant", 32'(Grant), 32'h2);
        chk("wd_tdata", 32'(T_Data), 32'h22);
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (T_Start) starts++;
        end
        chk("wd_no_regrant", 32'(starts), 32'd0);
        // reset during guard
        Req = 4'b0001;
        wait_start(cyc);
        Req = '0;
        tick();
        tick();
        tick();
        chk("rg_busy_pre", 32'(Busy), 32'd1);
        Reset = 1'b0;
        #1;
        chk("rg_busy", 32'(Busy), 32'd0);
        chk("rg_tstart", 32'(T_Start), 32'd0);
        chk("rg_grant", 32'(Grant), 32'd0);
        chk("rg_tdata", 32'(T_Data), 32'd0);
        tick();
        Reset = 1'b1;
        Req = 4'b1111;
        wait_start(cyc);
        chk("rg_lat", 32'(cyc), 32'd1);
        chk("rg_first_grant", 32'(Grant), 32'h1);
        Req = '0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cdc_tx_arbiter.md
# cdc_tx_arbiter

Transmit-domain scheduler that shares one clock-domain-crossing handshake channel among `NUM_REQ` requesters. It selects one pending requester with round-robin arbitration, captures that requester's word, and drives a single-cycle start pulse and stable data into the channel's transmitter side. It then holds off further starts for a guard window that covers the channel's worst-case request/acknowledge round trip. It sits in the transmitter clock domain, directly in front of the handshake channel, and uses the same clock and reset as the channel's transmitter side.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `WID_DATA`, default 8: width of the transferred word.
- `GUARD_CYCLES`, default 12: number of idle cycles forced after each start pulse; must be ≥ 1.

- `Clock` input, 1 bit: transmitter clock. One clock domain only.
- `Reset` input, 1 bit: asynchronous, active-low reset.
- `Req` input, `NUM_REQ` bits: level request, one bit per requester; each requester holds its bit until it is granted.
- `ReqData` input, `NUM_REQ*WID_DATA` bits: requester i drives its word on bits [i*WID_DATA +: WID_DATA]; the word is held stable while `Req[i]` is high.
- `Grant` output, `NUM_REQ` bits: one-hot, 1-cycle pulse to the requester being served.
- `T_Data` output, `WID_DATA` bits: word to the channel; registered.
- `T_Start` output, 1 bit: 1-cycle start pulse to the channel.
- `Busy` output, 1 bit: high while the block is in ISSUE or GUARD.

## Operation
- States: IDLE, ISSUE, GUARD.
- IDLE:
  - If `Req` is nonzero, select a winner, register its `ReqData` slice into `T_Data` and the winner's index into `Sel`, then go to ISSUE.
  - Otherwise remain in IDLE.
- ISSUE (exactly 1 cycle):
  - `T_Start`=1 and `Grant[Sel]`=1.
  - Update the round-robin pointer to `Sel`.
  - Load the guard counter with `GUARD_CYCLES-1` and go to GUARD.
- GUARD:
  - Decrement the counter each cycle; at 0, go to IDLE.
  - `Req` is ignored throughout GUARD.
- Round-robin: search starts at index pointer+1 and wraps modulo `NUM_REQ`; the first set `Req` bit wins.
- Pointer reset value is `NUM_REQ-1`, so index 0 has top priority after reset.
- `T_Data` holds its value from capture until the next capture; it never changes during ISSUE or GUARD.
- Protocol rules for requesters:
  - A requester drops `Req` in the cycle after it samples `Grant`.
  - A request already latched in IDLE always completes, even if `Req` falls during ISSUE.
  - If a requester keeps `Req` high after its grant, it is treated as a new request at the next IDLE.
- Sizing: `GUARD_CYCLES` ≥ 4 + 6·ceil(T_Tclk_period_ratio). The ratio is the receiver clock period over the transmitter clock period. This covers 2 receive synchronizer stages, 2 receive cycles before acknowledge, and 2 transmit synchronizer stages. A smaller value causes the channel to drop starts silently; that is an integration error and is not detected by this block.

## Timing
- Reset values: `T_Start`=0, `Grant`=0, `T_Data`=0, `Busy`=0, state=IDLE, pointer=`NUM_REQ-1`, counter=0.
- Latency: a request first seen in IDLE at cycle N gives `T_Start`/`Grant` at cycle N+1.
- Back-to-back throughput: one transfer every `GUARD_CYCLES`+2 cycles. That is 1 IDLE cycle, 1 ISSUE cycle and `GUARD_CYCLES` GUARD cycles.
- `Busy` rises in the ISSUE cycle and falls when the state returns to IDLE.
- Reset asserted mid-operation returns the block to IDLE immediately and clears all outputs, including any in-flight `T_Start` or `Grant`. The channel shares the same reset.
- Counter width is $clog2(`GUARD_CYCLES`+1); the counter never wraps.

## Configuration
- `CDC_ARB_FIXED_PRIO_EN` defined: fixed priority; the lowest set `Req` index always wins. The pointer register is removed.
- `CDC_ARB_FIXED_PRIO_EN` undefined (default): round-robin arbitration as described in Operation.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package `cdc_arb_pkg` contains:
  - the state encoding constants `ST_IDLE`=2'd0, `ST_ISSUE`=2'd1, `ST_GUARD`=2'd2;
  - the counter-width helper function.
- Sub-module `arb_rr_picker`: combinational mask-and-priority logic.
  - Inputs: `Req` and pointer.
  - Outputs: one-hot winner and index.
  - With `CDC_ARB_FIXED_PRIO_EN` defined, it reduces to a lowest-index priority encoder.

## Test plan
- Single request: `Req`=4'b0100 with slice 2 = 8'hA5 → `T_Start`/`Grant`=4'b0100 one cycle later; `T_Data`=8'hA5; `Busy` high for 13 cycles.
- All requesting: `Req`=4'b1111 held continuously → grant order 0,1,2,3,0 with starts spaced 14 cycles apart (12 guard cycles + 2).
- Requests arriving in GUARD: `Req[3]` rises during guard cycle 5 → no start until IDLE; the start occurs exactly 1 cycle after IDLE is entered.
- Withdrawn request: `Req[1]` falls in the ISSUE cycle → the transfer still completes; no second grant to requester 1.
- Reset during GUARD: `Reset`=0 → all outputs 0 and pointer=3 immediately; after release, `Req`=4'b1111 grants index 0 first.
- `CDC_ARB_FIXED_PRIO_EN` build: `Req`=4'b1111 held continuously → requester 0 granted every transfer.
